mem_arbiter: RTL and testbench

//  Shares one single-port unified memory between the instruction-fetch port
//  and the load/store data port of the rv64 core. Serialises requests via a
//  req/gnt handshake, drives the memory with registered controls, waits a

---
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter for a single-port memory: data port has priority, fetch
// port is protected from starvation, one transaction in flight at a time.
module mem_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_len,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_len,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam int STV_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_len_q, mem_len_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              fetch_wins;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      cnt_q       <= '0;
      starve_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_len_q   <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_len_q   <= mem_len_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // owner_q: 1 = data port owns the transaction in flight, 0 = fetch port
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_len_d   = mem_len_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;
    fetch_wins  = if_req && (!d_req || (starve_q == STV_W'(STARVE_MAX)));
    unique case (state_q)
      IDLE: begin
        if (rst && (if_req || d_req)) begin
          state_d = ISSUE;
          if (fetch_wins) begin
            if_gnt     = 1'b1;
            owner_d    = 1'b0;
            mem_we_d   = 1'b0;
            mem_addr_d = if_addr;
            starve_d   = '0;
          end else begin
            d_gnt       = 1'b1;
            owner_d     = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_len_d   = d_len;
            if (if_req) starve_d = starve_q + STV_W'(1);
          end
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(MEM_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = RESP;
          if (owner_q) d_rdata_d = mem_we_q ? '0 : mem_rdata;
          else         if_rdata_d = mem_rdata;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_len   = mem_len_q;
  assign if_rvalid = (state_q == RESP) && !owner_q;
  assign d_rvalid  = (state_q == RESP) && owner_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table for basic fetch/store/load,
// plus hand sequences for starvation, held-off requests and mid-access reset.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [10:0] if_addr, d_addr;
  logic [63:0] d_wdata;
  logic [3:0]  d_len;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
  logic [63:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [10:0] mem_addr;
  logic [3:0]  mem_len;

  int compared   = 0;
  int mismatched = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_len(d_len), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_len(mem_len), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: two-cycle read pipeline so data appears in cycle E+2
  logic [63:0] mem [0:2047];
  logic [63:0] rdPipe0, rdPipe1;

  function automatic logic [63:0] word(input logic [10:0] a);
    return {16'hC0DE, 37'd0, a};
  endfunction

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = word(11'(i));
    rdPipe0 = '0;
    rdPipe1 = '0;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      rdPipe0 <= mem[mem_addr];
      if (mem_we) mem[mem_addr] <= mem_wdata;
    end
    rdPipe1 <= rdPipe0;
  end
  assign mem_rdata = rdPipe1;

  typedef struct {
    logic        ifReq;
    logic [10:0] ifAddr;
    logic        dReq, dWe;
    logic [10:0] dAddr;
    logic [63:0] dWdata;
    logic [3:0]  dLen;
    logic        eIfGnt, eDGnt, eMemEn, eMemWe;
    logic [10:0] eMemAddr;
    logic [63:0] eMemWdata;
    logic [3:0]  eMemLen;
    logic        eIfRv, eDRv;
    logic [63:0] eRdata;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    if_req  = v.ifReq;
    if_addr = v.ifAddr;
    d_req   = v.dReq;
    d_we    = v.dWe;
    d_addr  = v.dAddr;
    d_wdata = v.dWdata;
    d_len   = v.dLen;
  endtask

  task automatic checkOutput(input vec_t v);
    check("ifGnt",    64'(if_gnt),    64'(v.eIfGnt));
    check("dGnt",     64'(d_gnt),     64'(v.eDGnt));
    check("memEn",    64'(mem_en),    64'(v.eMemEn));
    check("ifRvalid", 64'(if_rvalid), 64'(v.eIfRv));
    check("dRvalid",  64'(d_rvalid),  64'(v.eDRv));
    if (v.eMemEn) begin
      check("memWe",   64'(mem_we),   64'(v.eMemWe));
      check("memAddr", 64'(mem_addr), 64'(v.eMemAddr));
      if (v.eMemWe) begin
        check("memWdata", mem_wdata,    v.eMemWdata);
        check("memLen",   64'(mem_len), 64'(v.eMemLen));
      end
    end
    if (v.eIfRv) check("ifRdata", if_rdata, v.eRdata);
    if (v.eDRv)  check("dRdata",  d_rdata,  v.eRdata);
  endtask

  task automatic clearInputs();
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_len = '0;
  endtask

  initial begin
    int nG, last, c, lat;
    vec_t z;
    z = '{default: '0};
    for (int i = 0; i < 15; i++) vecs[i] = z;
    // fetch 0x010
    vecs[0].ifReq = 1'b1; vecs[0].ifAddr = 11'h010; vecs[0].eIfGnt = 1'b1;
    vecs[1].eMemEn = 1'b1; vecs[1].eMemAddr = 11'h010;
    vecs[4].eIfRv = 1'b1; vecs[4].eRdata = 64'hC0DE_0000_0000_0010;
    // store 0xDEAD to 0x100
    vecs[5].dReq = 1'b1; vecs[5].dWe = 1'b1; vecs[5].dAddr = 11'h100;
    vecs[5].dWdata = 64'hDEAD; vecs[5].dLen = 4'd8; vecs[5].eDGnt = 1'b1;
    vecs[6].eMemEn = 1'b1; vecs[6].eMemWe = 1'b1; vecs[6].eMemAddr = 11'h100;
    vecs[6].eMemWdata = 64'hDEAD; vecs[6].eMemLen = 4'd8;
    vecs[9].eDRv = 1'b1; vecs[9].eRdata = 64'h0;
    // load back 0x100
    vecs[10].dReq = 1'b1; vecs[10].dAddr = 11'h100; vecs[10].eDGnt = 1'b1;
    vecs[11].eMemEn = 1'b1; vecs[11].eMemAddr = 11'h100;
    vecs[14].eDRv = 1'b1; vecs[14].eRdata = 64'hDEAD;

    // reset with both requests pending: grants must stay low
    rst = 1'b0;
    clearInputs();
    if_req = 1'b1; d_req = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rstIfGnt",    64'(if_gnt),    64'd0);
    check("rstDGnt",     64'(d_gnt),     64'd0);
    check("rstMemEn",    64'(mem_en),    64'd0);
    check("rstIfRvalid", 64'(if_rvalid), 64'd0);
    check("rstDRvalid",  64'(d_rvalid),  64'd0);
    check("rstIfRdata",  if_rdata,       64'd0);
    check("rstMemAddr",  64'(mem_addr),  64'd0);
    @(negedge clk);
    clearInputs();
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput(vecs[i]);
    end

    // both requests held: expect D,D,D,D,IF repeating, grants 5 cycles apart
    @(negedge clk);
    clearInputs();
    if_req = 1'b1; if_addr = 11'h060; d_req = 1'b1; d_addr = 11'h070;
    nG = 0; last = 0; c = 0;
    while (c < 80 && nG < 10) begin
      #1;
      if (if_gnt || d_gnt) begin
        check("starveBothGnt", 64'(if_gnt && d_gnt), 64'd0);
        check("starveOrder", 64'(if_gnt), 64'((nG == 4) || (nG == 9)));
        if (nG > 0) check("grantSpacing", 64'(c - last), 64'd5);
        last = c;
        nG++;
      end
      @(negedge clk);
      c++;
    end
    check("starveGrantCount", 64'(nG), 64'd10);
    clearInputs();
    repeat (6) @(negedge clk);

    // request raised during WAIT is held off until IDLE
    if_req = 1'b1; if_addr = 11'h020;
    #1 check("heldIfGnt", 64'(if_gnt), 64'd1);
    @(negedge clk); if_req = 1'b0;
    #1 check("heldMemAddr", 64'(mem_addr), 64'h020);
    @(negedge clk); d_req = 1'b1; d_addr = 11'h030;
    #1 check("heldNoGntW1", 64'(d_gnt), 64'd0);
    @(negedge clk);
    #1 check("heldNoGntW2", 64'(d_gnt), 64'd0);
    @(negedge clk);
    #1 check("heldNoGntResp", 64'(d_gnt), 64'd0);
    check("heldIfRdata", if_rdata, word(11'h020));
    @(negedge clk);
    #1 check("heldDGntIdle", 64'(d_gnt), 64'd1);
    @(negedge clk); d_req = 1'b0;
    repeat (3) @(negedge clk);
    #1 check("heldDRvalid", 64'(d_rvalid), 64'd1);
    check("heldDRdata", d_rdata, word(11'h030));
    check("ifRdataStable", if_rdata, word(11'h020));
    @(negedge clk);

    // reset during WAIT drops the access; pending fetch served afterwards
    if_req = 1'b1; if_addr = 11'h040;
    #1 check("rstSeqIfGnt", 64'(if_gnt), 64'd1);
    @(negedge clk); if_req = 1'b0;
    @(negedge clk); rst = 1'b0; if_req = 1'b1; if_addr = 11'h050;
    #1;
    check("midRstOut", 64'({if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid}), 64'd0);
    check("midRstMemAddr", 64'(mem_addr), 64'd0);
    check("midRstMemWdata", mem_wdata, 64'd0);
    check("midRstIfRdata", if_rdata, 64'd0);
    check("midRstDRdata", d_rdata, 64'd0);
    lat = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 if (if_rvalid || d_rvalid || if_gnt) lat++;
    end
    check("midRstQuiet", 64'(lat), 64'd0);
    @(negedge clk); rst = 1'b1;
    #1 check("postRstIfGnt", 64'(if_gnt), 64'd1);
    @(negedge clk); if_req = 1'b0;
    lat = 1;
    #1;
    while (!if_rvalid && lat < 12) begin
      @(negedge clk);
      #1 lat++;
    end
    check("postRstLatency", 64'(lat), 64'd4);
    check("postRstIfRdata", if_rdata, word(11'h050));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
